cordic_prerotator: RTL and testbench

CORDIC_PREROTATOR -- requirements
Module: cordic_prerotator

---
 rtl/cordic_prerotator.sv | 168 ++++++++++++++++
 tb/tb_cordic_prerotator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_prerotator.sv
// Quadrant pre-rotation front end for a CORDIC core: folds any input vector/angle
// into the first quadrant, with a one-output-plus-one-skid elastic buffer.
`timescale 1ns/1ps
module cordic_prerotator #(
  parameter int DATA_W = 16,
  parameter int ANG_W  = 16,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic [ANG_W-1:0]         theta_in,
  input  logic [TAG_W-1:0]         tag_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] x_out,
  output logic signed [DATA_W-1:0] y_out,
  output logic [ANG_W-1:0]         theta_out,
  output logic [1:0]               quadrant,
  output logic                     mode_out,
  output logic [TAG_W-1:0]         tag_out,
  output logic                     sat
);

  localparam logic signed [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic [ANG_W-1:0]         theta;
    logic [1:0]               q;
    logic                     mode;
    logic [TAG_W-1:0]         tag;
    logic                     sat;
  } beat_t;

  function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] v);
    if (v == MIN_NEG) return MAX_POS;
    return -v;
  endfunction

  function automatic logic neg_ovf(input logic signed [DATA_W-1:0] v);
    return (v == MIN_NEG);
  endfunction

  beat_t                     w_beat_p0;
  logic [1:0]                w_q_p0;
  logic signed [DATA_W-1:0]  w_nx_p0;
  logic signed [DATA_W-1:0]  w_ny_p0;
  logic                      w_xmin_p0;
  logic                      w_ymin_p0;

  beat_t r_out_p1;
  beat_t r_skid_p1;
  logic  r_vld_p1;
  logic  r_skid_vld_p1;
  logic  r_in_ready;

  logic w_accept;
  logic w_out_free;
  logic w_vld_nxt;
  logic w_skid_vld_nxt;
  logic w_load_out;
  logic w_out_sel_skid;
  logic w_load_skid;

  // Stage p0: quadrant selection and exact 90-degree fold of the incoming beat
  always_comb begin
    w_beat_p0 = '0;
    w_nx_p0   = neg_sat(x_in);
    w_ny_p0   = neg_sat(y_in);
    w_xmin_p0 = neg_ovf(x_in);
    w_ymin_p0 = neg_ovf(y_in);
    if (!mode) begin
      w_q_p0          = theta_in[ANG_W-1:ANG_W-2];
      w_beat_p0.theta = {2'b00, theta_in[ANG_W-3:0]};
    end else begin
      w_q_p0          = x_in[DATA_W-1] ? (y_in[DATA_W-1] ? 2'd2 : 2'd1)
                                       : (y_in[DATA_W-1] ? 2'd3 : 2'd0);
      w_beat_p0.theta = theta_in + {w_q_p0, {(ANG_W-2){1'b0}}};
    end
    w_beat_p0.q    = w_q_p0;
    w_beat_p0.mode = mode;
    w_beat_p0.tag  = tag_in;
    case (w_q_p0)
      2'd0: begin
        w_beat_p0.x   = x_in;
        w_beat_p0.y   = y_in;
        w_beat_p0.sat = 1'b0;
      end
      2'd1: begin
        w_beat_p0.x   = y_in;
        w_beat_p0.y   = w_nx_p0;
        w_beat_p0.sat = w_xmin_p0;
      end
      2'd2: begin
        w_beat_p0.x   = w_nx_p0;
        w_beat_p0.y   = w_ny_p0;
        w_beat_p0.sat = w_xmin_p0 | w_ymin_p0;
      end
      default: begin
        w_beat_p0.x   = w_ny_p0;
        w_beat_p0.y   = x_in;
        w_beat_p0.sat = w_ymin_p0;
      end
    endcase
  end

  always_comb begin
    w_accept       = in_valid && r_in_ready;
    w_out_free     = !r_vld_p1 || out_ready;
    w_vld_nxt      = r_vld_p1;
    w_skid_vld_nxt = r_skid_vld_p1;
    w_load_out     = 1'b0;
    w_out_sel_skid = 1'b0;
    w_load_skid    = 1'b0;
    if (w_out_free) begin
      // in_ready is low whenever the skid is full, so no accept competes with the refill
      if (r_skid_vld_p1) begin
        w_load_out     = 1'b1;
        w_out_sel_skid = 1'b1;
        w_skid_vld_nxt = 1'b0;
        w_vld_nxt      = 1'b1;
      end else begin
        w_load_out = w_accept;
        w_vld_nxt  = w_accept;
      end
    end else if (w_accept) begin
      w_load_skid    = 1'b1;
      w_skid_vld_nxt = 1'b1;
    end
  end

  // Stage p1: output register and skid register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_in_ready    <= 1'b0;
      r_out_p1      <= '0;
    end else begin
      r_vld_p1      <= w_vld_nxt;
      r_skid_vld_p1 <= w_skid_vld_nxt;
      r_in_ready    <= !w_skid_vld_nxt;
      if (w_load_out) r_out_p1 <= w_out_sel_skid ? r_skid_p1 : w_beat_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_skid) r_skid_p1 <= w_beat_p0;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_vld_p1;
  assign x_out     = r_out_p1.x;
  assign y_out     = r_out_p1.y;
  assign theta_out = r_out_p1.theta;
  assign quadrant  = r_out_p1.q;
  assign mode_out  = r_out_p1.mode;
  assign tag_out   = r_out_p1.tag;
  assign sat       = r_out_p1.sat;

endmodule

// File: tb/tb_cordic_prerotator.sv
// Scoreboard bench for cordic_prerotator: directed corner beats, backpressure,
// mid-stream reset, then randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_cordic_prerotator;
  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int TW   = 4;
  localparam int QTR  = 1 << (AW - 2);
  localparam int FULL = 1 << AW;
  localparam int MAXP = (1 << (DW - 1)) - 1;

  typedef struct {
    int x; int y; int th; int q; int mode; int tag; int sat;
  } exp_t;

  logic                 clk, rst, in_valid, in_ready, mode, out_valid, out_ready;
  logic signed [DW-1:0] x_in, y_in, x_out, y_out;
  logic [AW-1:0]        theta_in, theta_out;
  logic [TW-1:0]        tag_in, tag_out;
  logic [1:0]           quadrant;
  logic                 mode_out, sat;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_deliv = 0;
  exp_t sb[$];

  cordic_prerotator #(.DATA_W(DW), .ANG_W(AW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_in(x_in), .y_in(y_in), .theta_in(theta_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out),
    .theta_out(theta_out), .quadrant(quadrant), .mode_out(mode_out),
    .tag_out(tag_out), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: quadrant from angle or signs, then multiply by the unit rotation
  // (cos, sin) of -q*90 degrees and clamp to the representable range.
  function automatic exp_t model(int m, int x, int y, int th, int tag);
    exp_t e;
    int c, s, xo, yo;
    if (m == 0) e.q = th / QTR;
    else if (x >= 0) e.q = (y >= 0) ? 0 : 3;
    else e.q = (y >= 0) ? 1 : 2;
    e.th = (m == 0) ? (th % QTR) : ((th + e.q * QTR) % FULL);
    c = (e.q == 0) ? 1 : (e.q == 2) ? -1 : 0;
    s = (e.q == 1) ? 1 : (e.q == 3) ? -1 : 0;
    xo = c * x + s * y;
    yo = c * y - s * x;
    e.sat = 0;
    if (xo > MAXP) begin xo = MAXP; e.sat = 1; end
    if (yo > MAXP) begin yo = MAXP; e.sat = 1; end
    e.x = xo; e.y = yo; e.mode = m; e.tag = tag;
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) sb.delete();
    else if (in_valid && in_ready)
      sb.push_back(model(int'(mode), int'(x_in), int'(y_in), int'(theta_in), int'(tag_in)));
  end

  logic [2*DW+AW+TW+5:0] cur_v, held_v;
  bit   stalled = 0;
  exp_t e_pop;

  always @(negedge clk) begin
    cur_v = {out_valid, x_out, y_out, theta_out, quadrant, mode_out, tag_out, sat};
    if (rst) stalled = 0;
    else begin
      if (stalled) begin
        n_cmp++;
        if (cur_v !== held_v) begin
          n_err++;
          $display("FAIL hold_stable act=%h req=%h", cur_v, held_v);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        n_deliv++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat act tag=%0d x=%0d req no beat outstanding", tag_out, x_out);
        end else begin
          e_pop = sb.pop_front();
          if (int'(x_out) != e_pop.x || int'(y_out) != e_pop.y || int'(theta_out) != e_pop.th ||
              int'(quadrant) != e_pop.q || int'(mode_out) != e_pop.mode ||
              int'(tag_out) != e_pop.tag || int'(sat) != e_pop.sat) begin
            n_err++;
            $display("FAIL beat act x=%0d y=%0d th=%0h q=%0d m=%0d tag=%0d sat=%0d req x=%0d y=%0d th=%0h q=%0d m=%0d tag=%0d sat=%0d",
                     x_out, y_out, theta_out, quadrant, mode_out, tag_out, sat,
                     e_pop.x, e_pop.y, e_pop.th, e_pop.q, e_pop.mode, e_pop.tag, e_pop.sat);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held_v  = cur_v;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic send(input logic m, input logic [DW-1:0] x, input logic [DW-1:0] y,
                      input logic [AW-1:0] th, input logic [TW-1:0] tg);
    mode = m; x_in = x; y_in = y; theta_in = th; tag_in = tg; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_cmp++; n_err++;
    $display("FAIL send_timeout act=no accept req=accept tag=%0d", tg);
    in_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int guard;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
    x_in = '0; y_in = '0; theta_in = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_fields", int'({x_out, y_out, theta_out, quadrant, mode_out, tag_out, sat} != '0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", int'(in_ready), 1);
    chk("idle_out_valid", int'(out_valid), 0);

    out_ready = 1'b1;
    send(1'b0, 16'h4000, 16'h0000, 16'h6000, 4'd1);
    @(negedge clk);
    chk("rot_latency_valid", int'(out_valid), 1);
    chk("rot_x", int'(x_out), 0);
    chk("rot_y", int'(y_out), int'(16'shC000));
    chk("rot_theta", int'(theta_out), 'h2000);
    chk("rot_q", int'(quadrant), 1);
    chk("rot_sat", int'(sat), 0);

    send(1'b1, 16'hC000, 16'h2000, 16'hF000, 4'd2);
    @(negedge clk);
    chk("vec_x", int'(x_out), 'h2000);
    chk("vec_y", int'(y_out), 'h4000);
    chk("vec_q", int'(quadrant), 1);
    chk("vec_theta_wrap", int'(theta_out), 'h3000);

    send(1'b0, 16'h8000, 16'h0001, 16'h8000, 4'd3);
    @(negedge clk);
    chk("sat_x", int'(x_out), 'h7FFF);
    chk("sat_y", int'(y_out), -1);
    chk("sat_q", int'(quadrant), 2);
    chk("sat_flag", int'(sat), 1);

    // Backpressure: fill output and skid, then release
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(1'b0, 16'h1234, 16'h0042, 16'h1000, 4'd1);
    send(1'b1, 16'h8000, 16'h8000, 16'hC123, 4'd2);
    mode = 1'b1; x_in = 16'h0100; y_in = 16'hFF00; theta_in = 16'hFFFF; tag_in = 4'd3;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_hold_tag1", int'(tag_out), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_deliver_tag1", int'(tag_out), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_deliver_tag2", int'(tag_out), 2);
    chk("bp_in_ready_rise", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_deliver_tag3", int'(tag_out), 3);
    chk("bp_tag3_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_empty_after", int'(out_valid), 0);

    // Mid-stream reset with two beats stored
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(1'b0, 16'h0011, 16'h0022, 16'h4000, 4'd5);
    send(1'b0, 16'h0033, 16'h0044, 16'h8000, 4'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready_after", int'(in_ready), 1);
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_no_stale", int'(out_valid), 0);
    end

    // Randomized traffic with random backpressure
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom_range(0, 1));
      x_in      = pick();
      y_in      = pick();
      theta_in  = ($urandom_range(0, 15) == 0) ? 16'hFFFF : AW'($urandom);
      tag_in    = TW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_pending", sb.size(), 0);

    // Full-rate streaming
    d0 = n_deliv;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      mode     = 1'($urandom_range(0, 1));
      x_in     = pick();
      y_in     = pick();
      theta_in = AW'($urandom);
      tag_in   = TW'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("throughput", n_deliv - d0, 100);
    chk("final_pending", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
